spi_byte_master: RTL and testbench
==================================

Name: spi_byte_master

Overview:
- Byte-level SPI master (mode 0, MSB first) that talks to the uALFAT SD/FAT controller.
- Sits directly downstream of spi_interface: spi_interface issues command bytes over a valid/ready handshake; this block serialises them onto SPI_SCK/SPI_MOSI/SPI_SSEL.
- Honours the uALFAT SPI_BUSY flow-control line before every byte and returns the simultaneously received MISO byte.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period (min 1); 25 MHz clk gives 3.125 MHz SCK.
- SSEL_SETUP, 2: clk cycles from SSEL falling to start of first SCK low phase.
- SSEL_GAP, 8: clk cycles SSEL is held high after a frame ends, before the next accept.

Ports:
- clk  in  1  system clock (25 MHz)
- reset_n  in  1  reset, synchronous, active-low
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data/tx_last valid
- tx_last  in  1  final byte of frame; SSEL deasserts after it
- tx_ready  out  1  block can accept a byte
- rx_data  out  8  byte shifted in from MISO
- rx_valid  out  1  one-cycle strobe, rx_data valid
- SPI_BUSY  in  1  uALFAT busy, asynchronous, high = busy
- SPI_MISO  in  1  serial data from uALFAT
- SPI_SCK  out  1  serial clock, idles low
- SPI_MOSI  out  1  serial data to uALFAT
- SPI_SSEL  out  1  chip select, active-low
- active  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (reset_n low at a clk edge): state IDLE, SPI_SSEL=1, SPI_SCK=0, SPI_MOSI=0, tx_ready=0 during reset and 1 from the first cycle after release, rx_valid=0, rx_data=0, active=0, frame_open=0, busy synchronisers=0.
- Reset mid-byte: the in-flight byte is discarded, no rx_valid is generated, and SSEL rises in the same cycle.
- SPI_BUSY passes through a 2-flop synchroniser; busy_s is the output.
- Handshake:
  - tx_ready=1 only in IDLE.
  - A transfer is accepted when tx_valid&tx_ready at a clk edge; tx_data and tx_last are latched.
  - tx_valid while tx_ready=0 is ignored; the upstream block holds it.
- WAIT_BUSY (entered on accept):
  - Stays while busy_s=1.
  - When busy_s=0 and frame_open=0: drive SSEL=0, set frame_open, go to SETUP.
  - When busy_s=0 and frame_open=1: go directly to SHIFT_LO.
- SETUP: SSEL low, SCK low, MOSI=bit7; lasts SSEL_SETUP cycles, then SHIFT_LO.
- SHIFT_LO:
  - SCK=0, MOSI=current bit (MSB first); lasts CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI:
  - SCK=1 for CLK_DIV cycles.
  - SPI_MISO is sampled into the rx shift register on the clk edge at which SCK rises.
  - Bit counter increments on exit.
  - After bits 0..6: back to SHIFT_LO with the next MOSI bit.
  - After bit 7: go to DONE.
- DONE (1 cycle):
  - SCK=0, rx_data=shift register, rx_valid=1.
  - If latched last=1: go to GAP.
  - Otherwise: go to IDLE with SSEL held low.
- GAP:
  - SSEL=1, clear frame_open, MOSI=0; lasts SSEL_GAP cycles, then IDLE.
- Byte timing: 16*CLK_DIV cycles from the first SHIFT_LO cycle to DONE. SCK never glitches; SSEL changes only while SCK=0.
- SPI_BUSY rising mid-byte does not pause the shift. It is only checked in WAIT_BUSY, before each byte.
- Back-to-back bytes: a new accept in IDLE with the frame open re-checks busy and keeps SSEL low throughout.
- A tx_last=1 byte sent with the frame already open closes the frame.

Test Plan:
- Single byte: reset, tx_data=0xA5, tx_last=1, SPI_BUSY=0, MISO tied to a 0x3C pattern.
  - MOSI samples at the 8 SCK rises = 1,0,1,0,0,1,0,1.
  - rx_data=0x3C with a one-cycle rx_valid.
  - SSEL low to high spans SSEL_SETUP+16*CLK_DIV+1=67 cycles.
- Busy hold: SPI_BUSY=1 at accept, released 200 cycles later.
  - SSEL stays high and SCK idle until 2-3 cycles after release; then a normal byte follows.
- Multi-byte frame: bytes 0x01,0x02,0x03, last=1 on 0x03.
  - SSEL stays low across all three, with three rx_valid pulses.
  - SSEL rises after the third byte and stays high for 8 cycles before tx_ready=1.
- Handshake: tx_valid held high with 0x55 while a byte is in progress.
  - Not accepted until tx_ready=1; exactly one copy of 0x55 is transmitted.
- Reset mid-byte: assert reset_n=0 after the 3rd SCK rise.
  - Next edge: SSEL=1, SCK=0, MOSI=0, no rx_valid.
  - A subsequent 0xFF byte transfers cleanly.
- CLK_DIV=1: 0x80 with last=1 → SCK period 2 clk cycles, MOSI bits 1,0,0,0,0,0,0,0, byte time 16 cycles.

Source files
------------

// File: rtl/spi_byte_master_if.sv
// Byte handshake between the command sequencer and the SPI byte master.
// The master modport is the upstream side; the slave modport is the serialiser.
interface spi_byte_master_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output tx_data, tx_valid, tx_last,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, tx_last,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_byte_master.sv
// Mode-0, MSB-first SPI byte master for the uALFAT: waits on SPI_BUSY before each
// byte, keeps SSEL low across a multi-byte frame and returns the MISO byte.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a byte; SSEL stays low if a frame is open
// WAIT_BUSY  | byte latched, waiting for synchronised SPI_BUSY to drop
// SETUP      | SSEL just fell, SSEL_SETUP cycles before the first SCK low
// SHIFT_LO   | SCK low, MOSI carries the current bit, CLK_DIV cycles
// SHIFT_HI   | SCK high, MISO sampled on entry, CLK_DIV cycles
// DONE       | one cycle, rx_valid strobe
// GAP        | frame closed, SSEL high for SSEL_GAP cycles
module spi_byte_master #(
  parameter int CLK_DIV    = 4,
  parameter int SSEL_SETUP = 2,
  parameter int SSEL_GAP   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  spi_byte_master_if.slave    bus,
  input  logic                SPI_BUSY,
  input  logic                SPI_MISO,
  output logic                SPI_SCK,
  output logic                SPI_MOSI,
  output logic                SPI_SSEL,
  output logic                active
);

  localparam int MAX_A  = (CLK_DIV > SSEL_SETUP) ? CLK_DIV : SSEL_SETUP;
  localparam int MAX_B  = (MAX_A > SSEL_GAP) ? MAX_A : SSEL_GAP;
  localparam int CNT_W  = (MAX_B > 1) ? $clog2(MAX_B) : 1;

  localparam logic [CNT_W-1:0] CNT_DIV   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(SSEL_SETUP - 1);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(SSEL_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_tx_shift;
  logic [7:0]       r_rx_shift;
  logic             r_last;
  logic             r_frame_open;
  logic             r_busy_meta;
  logic             r_busy_s;
  logic             r_ssel;
  logic             r_sck;
  logic             r_mosi;
  logic             r_tx_ready;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       w_tx_shift_nxt;
  logic [7:0]       w_rx_shift_nxt;
  logic             w_last_nxt;
  logic             w_frame_open_nxt;
  logic             w_ssel_nxt;
  logic             w_mosi_nxt;
  logic [7:0]       w_rx_data_nxt;
  logic             w_accept;
  logic             w_cnt_tc;

  assign w_accept = bus.tx_valid & r_tx_ready;
  assign w_cnt_tc = (r_cnt == '0);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_bit_idx_nxt    = r_bit_idx;
    w_tx_shift_nxt   = r_tx_shift;
    w_rx_shift_nxt   = r_rx_shift;
    w_last_nxt       = r_last;
    w_frame_open_nxt = r_frame_open;
    w_ssel_nxt       = r_ssel;
    w_mosi_nxt       = r_mosi;
    w_rx_data_nxt    = r_rx_data;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_tx_shift_nxt = bus.tx_data;
          w_last_nxt     = bus.tx_last;
          w_bit_idx_nxt  = 3'd0;
          w_state_nxt    = ST_WAIT_BUSY;
        end
      end

      ST_WAIT_BUSY: begin
        if (!r_busy_s) begin
          if (r_frame_open) begin
            w_state_nxt = ST_SHIFT_LO;
            w_cnt_nxt   = CNT_DIV;
          end else begin
            w_frame_open_nxt = 1'b1;
            w_ssel_nxt       = 1'b0;
            if (SSEL_SETUP > 0) begin
              w_state_nxt = ST_SETUP;
              w_cnt_nxt   = CNT_SETUP;
            end else begin
              w_state_nxt = ST_SHIFT_LO;
              w_cnt_nxt   = CNT_DIV;
            end
          end
        end
      end

      ST_SETUP: begin
        if (w_cnt_tc) begin
          w_state_nxt = ST_SHIFT_LO;
          w_cnt_nxt   = CNT_DIV;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_SHIFT_LO: begin
        if (w_cnt_tc) begin
          // this edge raises SCK, so it is also the MISO sample point
          w_state_nxt    = ST_SHIFT_HI;
          w_cnt_nxt      = CNT_DIV;
          w_rx_shift_nxt = {r_rx_shift[6:0], SPI_MISO};
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_SHIFT_HI: begin
        if (w_cnt_tc) begin
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt   = ST_DONE;
            w_rx_data_nxt = r_rx_shift;
          end else begin
            w_state_nxt    = ST_SHIFT_LO;
            w_cnt_nxt      = CNT_DIV;
            w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (r_last) begin
          w_frame_open_nxt = 1'b0;
          w_ssel_nxt       = 1'b1;
          w_mosi_nxt       = 1'b0;
          if (SSEL_GAP > 0) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = CNT_GAP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (w_cnt_tc) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // MOSI is presented one cycle ahead of any SCK rise
    if (w_state_nxt == ST_SETUP || w_state_nxt == ST_SHIFT_LO) begin
      w_mosi_nxt = w_tx_shift_nxt[7];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_tx_shift   <= 8'h00;
      r_rx_shift   <= 8'h00;
      r_last       <= 1'b0;
      r_frame_open <= 1'b0;
      r_busy_meta  <= 1'b0;
      r_busy_s     <= 1'b0;
      r_ssel       <= 1'b1;
      r_sck        <= 1'b0;
      r_mosi       <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
    end else begin
      r_busy_meta  <= SPI_BUSY;
      r_busy_s     <= r_busy_meta;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_tx_shift   <= w_tx_shift_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_last       <= w_last_nxt;
      r_frame_open <= w_frame_open_nxt;
      r_ssel       <= w_ssel_nxt;
      r_sck        <= (w_state_nxt == ST_SHIFT_HI);
      r_mosi       <= w_mosi_nxt;
      r_tx_ready   <= (w_state_nxt == ST_IDLE);
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign SPI_SCK      = r_sck;
  assign SPI_MOSI     = r_mosi;
  assign SPI_SSEL     = r_ssel;
  assign active       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: default timing instance plus a CLK_DIV=1 instance,
// with a small uALFAT-style MISO responder.
module tb_spi_byte_master;
  logic clk = 1'b0;
  logic reset_n;
  logic SPI_BUSY, SPI_MISO, SPI_SCK, SPI_MOSI, SPI_SSEL, active;
  logic busy1, miso1, sck1, mosi1, ssel1, active1;

  spi_byte_master_if bus ();
  spi_byte_master_if bus1 ();

  spi_byte_master dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .SPI_BUSY(SPI_BUSY), .SPI_MISO(SPI_MISO), .SPI_SCK(SPI_SCK),
    .SPI_MOSI(SPI_MOSI), .SPI_SSEL(SPI_SSEL), .active(active)
  );

  spi_byte_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .SPI_BUSY(busy1), .SPI_MISO(miso1), .SPI_SCK(sck1),
    .SPI_MOSI(mosi1), .SPI_SSEL(ssel1), .active(active1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // responder: MSB first, next bit presented after each SCK rise
  logic [7:0]  miso_pat;
  logic [2:0]  slv_bit = 3'd0;
  int          sck_rises = 0;
  logic [31:0] mosi_log = '0;
  assign SPI_MISO = miso_pat[3'd7 - slv_bit];

  always @(posedge SPI_SCK or posedge SPI_SSEL) begin
    if (SPI_SSEL) slv_bit = 3'd0;
    else begin
      slv_bit   = slv_bit + 3'd1;
      sck_rises = sck_rises + 1;
      mosi_log  = {mosi_log[30:0], SPI_MOSI};
    end
  end

  int         rx_cnt = 0, ssel_run = 0, ssel_low_len = 0, sck_hi_cnt = 0;
  int         gap_cnt = 0, gap_len = 0, acc_cnt = 0, ssel_rise_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  logic       prev_ssel = 1'b1, in_gap = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = bus.rx_data;
    end
    if (bus.tx_valid && bus.tx_ready === 1'b1) acc_cnt = acc_cnt + 1;
    if (SPI_SCK === 1'b1) sck_hi_cnt = sck_hi_cnt + 1;
    if (SPI_SSEL === 1'b0) ssel_run = ssel_run + 1;
    else if (ssel_run != 0) begin
      ssel_low_len = ssel_run;
      ssel_run     = 0;
    end
    if (SPI_SSEL === 1'b1 && !prev_ssel) begin
      ssel_rise_cnt = ssel_rise_cnt + 1;
      in_gap        = 1'b1;
      gap_cnt       = 0;
    end
    if (in_gap) begin
      if (bus.tx_ready === 1'b1) begin
        gap_len = gap_cnt;
        in_gap  = 1'b0;
      end else if (SPI_SSEL === 1'b1) gap_cnt = gap_cnt + 1;
    end
    prev_ssel = (SPI_SSEL === 1'b1);
  end

  int         rx1_cnt = 0, ssel1_run = 0, ssel1_low_len = 0, sck1_hi = 0;
  int         cyc1 = 0, last_rise1 = 0, sck1_period = 0;
  logic [7:0] rx1_last = 8'h00;
  logic [7:0] mosi1_log = 8'h00;
  logic       prev_sck1 = 1'b0;

  always @(negedge clk) begin
    cyc1 = cyc1 + 1;
    if (bus1.rx_valid === 1'b1) begin
      rx1_cnt  = rx1_cnt + 1;
      rx1_last = bus1.rx_data;
    end
    if (sck1 === 1'b1) sck1_hi = sck1_hi + 1;
    if (sck1 === 1'b1 && !prev_sck1) begin
      sck1_period = cyc1 - last_rise1;
      last_rise1  = cyc1;
      mosi1_log   = {mosi1_log[6:0], mosi1};
    end
    prev_sck1 = (sck1 === 1'b1);
    if (ssel1 === 1'b0) ssel1_run = ssel1_run + 1;
    else if (ssel1_run != 0) begin
      ssel1_low_len = ssel1_run;
      ssel1_run     = 0;
    end
  end

  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    bus.tx_data  = d;
    bus.tx_last  = last;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("accept_wait", bus.tx_ready, 1'b1);
    tick();
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("idle_wait", bus.tx_ready, 1'b1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0, s0, h0, a0, q0, n, viol;
    reset_n = 1'b0;
    SPI_BUSY = 1'b0; busy1 = 1'b0; miso1 = 1'b1;
    miso_pat = 8'h3C;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.tx_last = 1'b0;
    bus1.tx_valid = 1'b0; bus1.tx_data = 8'h00; bus1.tx_last = 1'b0;
    repeat (3) tick();

    check("rst_ssel", SPI_SSEL, 1'b1);
    check("rst_sck", SPI_SCK, 1'b0);
    check("rst_mosi", SPI_MOSI, 1'b0);
    check("rst_tx_ready", bus.tx_ready, 1'b0);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_active", active, 1'b0);
    reset_n = 1'b1;
    tick();
    check("rel_tx_ready", bus.tx_ready, 1'b1);

    // single byte
    r0 = rx_cnt; s0 = sck_rises; h0 = sck_hi_cnt;
    send(8'hA5, 1'b1);
    check("t1_active", active, 1'b1);
    wait_idle();
    check("t1_rx_cnt", rx_cnt - r0, 1);
    check("t1_rx_last", rx_last, 8'h3C);
    check("t1_rx_data", bus.rx_data, 8'h3C);
    check("t1_sck_rises", sck_rises - s0, 8);
    check("t1_mosi", mosi_log[7:0], 8'hA5);
    check("t1_sck_hi", sck_hi_cnt - h0, 32);
    check("t1_ssel_low", ssel_low_len, 67);
    check("t1_gap", gap_len, 8);

    // busy hold
    SPI_BUSY = 1'b1;
    repeat (3) tick();
    r0 = rx_cnt;
    send(8'h96, 1'b1);
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (SPI_SSEL !== 1'b1 || SPI_SCK !== 1'b0) viol++;
    end
    check("t2_hold_idle", viol, 0);
    check("t2_active", active, 1'b1);
    SPI_BUSY = 1'b0;
    n = 0;
    while (SPI_SSEL === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t2_release_lat", (n >= 2 && n <= 3), 1'b1);
    wait_idle();
    check("t2_rx_cnt", rx_cnt - r0, 1);
    check("t2_rx_last", rx_last, 8'h3C);
    check("t2_mosi", mosi_log[7:0], 8'h96);
    check("t2_ssel_low", ssel_low_len, 67);

    // multi-byte frame
    r0 = rx_cnt; q0 = ssel_rise_cnt;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    wait_idle();
    check("t3_rx_cnt", rx_cnt - r0, 3);
    check("t3_ssel_rises", ssel_rise_cnt - q0, 1);
    check("t3_mosi", mosi_log[23:0], 24'h010203);
    check("t3_rx_last", rx_last, 8'h3C);
    check("t3_gap", gap_len, 8);

    // handshake: second byte held valid while first is shifting
    r0 = rx_cnt; s0 = sck_rises; a0 = acc_cnt;
    send(8'h33, 1'b1);
    send(8'h55, 1'b1);
    wait_idle();
    check("t4_accepts", acc_cnt - a0, 2);
    check("t4_sck_rises", sck_rises - s0, 16);
    check("t4_mosi", mosi_log[15:0], 16'h3355);
    check("t4_rx_cnt", rx_cnt - r0, 2);

    // reset mid-byte, with MOSI high at the moment of reset
    s0 = sck_rises;
    send(8'hE7, 1'b1);
    n = 0;
    while (sck_rises - s0 < 3 && n < 500) begin
      tick();
      n++;
    end
    check("t5_third_rise", sck_rises - s0, 3);
    r0 = rx_cnt;
    reset_n = 1'b0;
    tick();
    check("t5_ssel", SPI_SSEL, 1'b1);
    check("t5_sck", SPI_SCK, 1'b0);
    check("t5_mosi", SPI_MOSI, 1'b0);
    check("t5_rx_valid", bus.rx_valid, 1'b0);
    check("t5_active", active, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("t5_no_rx", rx_cnt - r0, 0);
    s0 = sck_rises;
    send(8'hFF, 1'b1);
    wait_idle();
    check("t5_rx_cnt", rx_cnt - r0, 1);
    check("t5_rx_last", rx_last, 8'h3C);
    check("t5_mosi_ff", mosi_log[7:0], 8'hFF);
    check("t5_rises", sck_rises - s0, 8);
    check("t5_ssel_low", ssel_low_len, 67);

    // CLK_DIV=1 instance
    h0 = sck1_hi; r0 = rx1_cnt;
    check("t6_ready", bus1.tx_ready, 1'b1);
    bus1.tx_data = 8'h80; bus1.tx_last = 1'b1; bus1.tx_valid = 1'b1;
    tick();
    bus1.tx_valid = 1'b0;
    n = 0;
    while (bus1.tx_ready !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    tick();
    check("t6_idle", bus1.tx_ready, 1'b1);
    check("t6_rx_cnt", rx1_cnt - r0, 1);
    check("t6_rx", rx1_last, 8'hFF);
    check("t6_mosi", mosi1_log, 8'h80);
    check("t6_sck_hi", sck1_hi - h0, 8);
    check("t6_period", sck1_period, 2);
    check("t6_ssel_low", ssel1_low_len, 19);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
